// File: rtl/wrr_pkg.sv
// Shared definitions for the weighted round-robin burst arbiter.
// Contents:
//   state_e       arbiter FSM state encoding (IDLE, BUSY)
//   N_DEF/CW_DEF  default requester count and weight field width
//   to_onehot()   index -> one-hot vector (up to MAX_N bits)
//   eff_weight()  burst weight with 0 promoted to 1
package wrr_pkg;

  localparam int N_DEF  = 4;
  localparam int CW_DEF = 4;
  localparam int MAX_N  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic [MAX_N-1:0] to_onehot(input logic [3:0] idx);
    logic [MAX_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // A zero weight would otherwise grant a burst of no beats.
  function automatic int unsigned eff_weight(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: returns the first set bit of req scanning
// ptr, ptr+1, ..., N-1, 0, ..., ptr-1. Purely combinational.
// Ports:
//   req   in  N    request vector
//   ptr   in  IDW  highest-priority position
//   found out 1    any request set
//   idx   out IDW  index of the selected requester (0 when none)
module rr_pick
  import wrr_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] cand;

  // Scan from lowest to highest priority so the last hit (closest to ptr) wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin burst arbiter. An owner keeps the grant for up to
// eff_weight(weight[owner]) beats (counted on done) or until it drops its
// request; ownership then rotates starting just after the old owner.
// Ports:
//   clk          in  1     system clock, rising edge
//   rst_n        in  1     asynchronous active-low reset
//   req          in  N     per-requester request level
//   weight       in  N*CW  packed burst weights, requester i at [i*CW +: CW]
//   done         in  1     one beat accepted from the current owner
//   grant        out N     registered one-hot grant, 0 when idle
//   grant_valid  out 1     registered OR of grant
//   grant_id     out IDW   owner index, 0 when idle
//   credit       out CW    beats left for the owner, 0 when idle
//
// state | meaning
// IDLE  | no owner; first requester from ptr is granted on the next edge
// BUSY  | owner held; counts beats, rotates on exhaustion or request drop
module wrr_burst_arbiter
  import wrr_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int CW  = CW_DEF,
  parameter int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*CW-1:0] weight,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_id,
  output logic [CW-1:0]   credit
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           valid_q, valid_d;
  logic [CW-1:0]  credit_q, credit_d;

  logic [IDW-1:0] next_ptr;
  logic [IDW-1:0] pick_ptr;
  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic           release_now;
  logic [CW-1:0]  new_credit;

  assign next_ptr    = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
  assign release_now = (done && (credit_q == CW'(1))) || !req[id_q];

  // While busy the only selection that matters is the post-release one,
  // so the picker looks ahead from the rotated pointer.
  assign pick_ptr = (state_q == BUSY) ? next_ptr : ptr_q;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign new_credit = CW'(eff_weight(32'(weight[int'(pick_idx)*CW +: CW])));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    credit_d = credit_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = BUSY;
          id_d     = pick_idx;
          grant_d  = N'(to_onehot(4'(pick_idx)));
          valid_d  = 1'b1;
          credit_d = new_credit;
        end
      end
      BUSY: begin
        if (release_now) begin
          ptr_d = next_ptr;
          if (pick_found) begin
            id_d     = pick_idx;
            grant_d  = N'(to_onehot(4'(pick_idx)));
            valid_d  = 1'b1;
            credit_d = new_credit;
          end else begin
            state_d  = IDLE;
            id_d     = '0;
            grant_d  = '0;
            valid_d  = 1'b0;
            credit_d = '0;
          end
        end else if (done) begin
          credit_d = credit_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      credit_q <= credit_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;
  assign credit      = credit_q;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
module tb_wrr_burst_arbiter;

  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*CW-1:0] weight = '0;
  logic            done = 1'b0;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IDW-1:0]  grant_id;
  logic [CW-1:0]   credit;

  wrr_burst_arbiter #(.N(N), .CW(CW), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .weight      (weight),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .credit      (credit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]   g;
    logic           v;
    logic [IDW-1:0] id;
    logic [CW-1:0]  c;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // reference model state
  bit m_busy;
  int m_ptr;
  int m_own;
  int m_cred;

  logic [3:0] rot_exp   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         wrr_exp   [6] = '{0, 0, 0, 1, 2, 3};
  int         burst_exp [4] = '{3, 2, 1, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic int m_w(input int i);
    int w;
    w = int'(weight[i*CW +: CW]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic d);
    int   w;
    exp_t e;
    if (!m_busy) begin
      w = m_pick(m_ptr, r);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_own  = w;
        m_cred = m_w(w);
      end
    end else if ((d && m_cred == 1) || !r[m_own]) begin
      m_ptr = (m_own + 1) % N;
      w = m_pick(m_ptr, r);
      if (w >= 0) begin
        m_own  = w;
        m_cred = m_w(w);
      end else begin
        m_busy = 1'b0;
        m_own  = 0;
        m_cred = 0;
      end
    end else if (d) begin
      m_cred--;
    end
    e.g  = m_busy ? N'(1 << m_own) : '0;
    e.v  = m_busy;
    e.id = m_busy ? IDW'(m_own) : '0;
    e.c  = m_busy ? CW'(m_cred) : '0;
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic d);
    exp_t e;
    req  = r;
    done = d;
    model_edge(r, d);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("grant", 32'(grant), 32'(e.g));
      chk("grant_valid", 32'(grant_valid), 32'(e.v));
      chk("grant_id", 32'(grant_id), 32'(e.id));
      chk("credit", 32'(credit), 32'(e.c));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_credit", 32'(credit), 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_busy = 1'b0;
    m_ptr  = 0;
    m_own  = 0;
    m_cred = 0;
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] r;
    #2;
    do_reset();

    // idle: no requests, done toggling must be ignored
    for (int i = 0; i < 5; i++) begin
      cycle('0, 1'(i % 2));
      chk("idle_grant", 32'(grant), 32'd0);
      chk("idle_credit", 32'(credit), 32'd0);
    end

    // single burst, sole requester re-granted without a gap
    weight = 16'h1113;
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0001, 1'b1);
      chk("burst_grant", 32'(grant), 32'b0001);
      chk("burst_credit", 32'(credit), 32'(burst_exp[i]));
    end
    cycle(4'b0000, 1'b0);
    chk("burst_drop", 32'(grant), 32'd0);

    // plain rotation with unit weights
    do_reset();
    weight = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b1);
      chk("rot_grant", 32'(grant), 32'(rot_exp[i]));
    end

    // weighted share 3:1:1:1
    do_reset();
    weight = 16'h1113;
    for (int i = 0; i < 12; i++) begin
      cycle(4'b1111, 1'b1);
      chk("wrr_id", 32'(grant_id), 32'(wrr_exp[i % 6]));
    end

    // stalls and voluntary release
    do_reset();
    weight = 16'h2411;
    cycle(4'b0100, 1'b0);
    chk("stall_first", 32'(credit), 32'd4);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1100, 1'b0);
      chk("stall_credit", 32'(credit), 32'd4);
      chk("stall_grant", 32'(grant), 32'b0100);
    end
    cycle(4'b1000, 1'b0);
    chk("vol_grant", 32'(grant), 32'b1000);
    chk("vol_credit", 32'(credit), 32'd2);
    cycle(4'b1000, 1'b1);
    cycle(4'b1000, 1'b1);
    chk("wrap_grant", 32'(grant), 32'b1000);
    cycle(4'b0001, 1'b1);
    chk("wrap_next", 32'(grant), 32'b0001);
    cycle(4'b0000, 1'b0);

    // zero weight acts as one; weight change applies at next grant
    do_reset();
    weight = 16'h1103;
    cycle(4'b0010, 1'b1);
    chk("w0_credit", 32'(credit), 32'd1);
    cycle(4'b0010, 1'b1);
    chk("w0_regrant", 32'(grant), 32'b0010);
    cycle(4'b0001, 1'b0);
    chk("wchg_first", 32'(credit), 32'd3);
    weight = 16'h1105;
    cycle(4'b0001, 1'b1);
    chk("wchg_hold", 32'(credit), 32'd2);
    cycle(4'b0001, 1'b1);
    cycle(4'b0001, 1'b1);
    chk("wchg_new", 32'(credit), 32'd5);

    // async reset in the middle of a burst
    do_reset();
    weight = 16'h1413;
    cycle(4'b0001, 1'b1);
    cycle(4'b0001, 1'b1);
    chk("mid_credit", 32'(credit), 32'd2);
    #2;
    do_reset();
    cycle(4'b0100, 1'b0);
    chk("post_rst_grant", 32'(grant), 32'b0100);
    chk("post_rst_credit", 32'(credit), 32'd4);
    cycle(4'b0000, 1'b0);
    do_reset();
    cycle(4'b1001, 1'b0);
    chk("rst_ptr", 32'(grant), 32'b0001);
    cycle(4'b0000, 1'b0);

    // random traffic against the model
    do_reset();
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) weight = 16'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      cycle(r, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
- Weighted round-robin scheduler that shares a single downstream resource among N requesters.
- A grant is held for up to a per-requester burst of "beats" (counted on done), then ownership rotates.
- Sits between requesting masters and the shared datapath.
- Extends the team's basic round-robin arbiter with burst/credit control and an owner-release handshake.

Parameters:
- N, 4, number of requesters (2..16)
- CW, 4, width of each per-requester weight/credit field
- IDW, $clog2(N), width of grant_id

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  N  per-requester request level; held high while requester wants the resource
- weight  input  N*CW  packed burst weights; requester i uses bits [i*CW +: CW]; static configuration
- done  input  1  resource accepted one beat from the current owner this cycle
- grant  output  N  one-hot registered grant; all zero when idle
- grant_valid  output  1  OR of grant; registered
- grant_id  output  IDW  binary index of owner; 0 when idle
- credit  output  CW  remaining beats for current owner; 0 when idle

Behaviour:
- Reset (async, rst_n=0): grant=0, grant_valid=0, grant_id=0, credit=0, state=IDLE, rotate pointer ptr=0. All outputs clear immediately, including mid-burst. First edge after rst_n rises behaves as IDLE.
- States: IDLE (no owner), BUSY (owner held).
- Winner selection (combinational, from ptr):
  - first i with req[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
- IDLE:
  - If req!=0 at edge t, then at t+1: grant=onehot(winner), grant_id=winner, credit=weight[winner], state=BUSY.
  - A weight of 0 is treated as 1.
  - Latency: request to grant is 1 clock.
- BUSY, per edge with owner o:
  - done=1 and credit>1 and req[o]=1: credit decrements; grant held.
  - Release occurs when done=1 and credit==1 (credit exhausted), or when req[o]=0 (voluntary drop). The two can occur together; a beat with done=1 counts before release.
  - On release: ptr=(o+1) mod N. Winner is computed from the new ptr in the same cycle, using current req with o's bit included.
    - Winner exists: the next grant loads at the same edge (back-to-back, no idle bubble) and credit reloads from the new owner's weight.
    - No winner: go to IDLE with grant=0 and credit=0.
  - If o is the sole requester at exhaustion, o is re-granted with full credit, so grant stays asserted continuously.
  - done=0 and req[o]=1: hold; credit unchanged.
  - done while idle is ignored.
- Weight is sampled only when a grant is issued; changes mid-burst take effect on the next grant to that requester.
- Non-owner req changes never preempt the owner.
- grant is always one-hot or zero; grant_valid==|grant; grant_id matches grant.
- Fairness: each continuously requesting requester is granted within sum(max(weight,1)) of the other requesters' beats.

Decomposition:
- Shared package wrr_pkg:
  - state enum {IDLE, BUSY}
  - N/CW defaults
  - helper function to_onehot(idx)
  - helper function eff_weight(w) returning max(w,1)
- Sub-module rr_pick:
  - purely combinational rotating-priority encoder
  - inputs req, ptr; outputs found, idx
  - reused wherever the team needs pointer-based selection.
- Top holds the FSM, ptr, credit and output registers.

Test Plan:
- Reset/idle: rst_n=0 then 1, req=0 for 5 clocks -> grant=0000, grant_valid=0, credit=0 throughout.
- Single burst: weights {w3..w0}={1,1,1,3}, req=0001, done=1 every cycle -> grant=0001 one clock after req.
  - credit 3,2,1, then re-granted 0001 with credit=3 (sole requester) and no gap.
- Rotation: req=1111, all weights 1, done=1 continuously, from reset -> grant sequence 0001,0010,0100,1000,0001 on consecutive clocks.
- Weighted share: weights {1,1,1,3}, req=1111, done=1 continuous -> per 6-cycle window, requester0 owns 3 cycles and each other owns 1; order 0,0,0,1,2,3.
- Voluntary release and stalls: owner 2 (weight 4) with done=0 for 3 cycles -> credit holds at 4.
  - Then req[2] drops with done=0 -> next edge grant moves to the next requester at or after 3, credit=that weight; ptr=3.
- Async reset mid-burst: assert rst_n=0 between edges while credit=2 -> grant=0 immediately, without waiting for a clock.
  - After release with req=0100, first grant goes to 0100 with full weight, arbitrated from ptr=0.
